// File: rtl/cpu_sequencer.sv
// Instruction sequencer for a multi-cycle core: FETCH/EXEC/WFI/TRAP control,
// PC update, fetch timeout, retired-instruction counting and sticky traps.
module cpu_sequencer #(
  parameter int unsigned       Width        = 32,
  parameter logic [Width-1:0]  ResetPc      = '0,
  parameter int unsigned       FetchTimeout = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             vld_decode,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_wfi,
  input  logic             rd_valid,
  input  logic             cmp_taken,
  input  logic [Width-1:0] imm,
  input  logic             irq,
  output logic [Width-1:0] pc,
  output logic             imem_valid,
  output logic             ir_load,
  output logic             rd_we,
  output logic             wb_link,
  output logic [Width-1:0] link_data,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [Width-1:0] instret
);

  localparam int unsigned CntW = $clog2(FetchTimeout + 1);

  typedef enum logic [1:0] {StFetch, StExec, StWfi, StTrap} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] instret_q, instret_d;
  logic [1:0]       cause_q, cause_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] target;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instret_d  = instret_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    imem_valid = 1'b0;
    ir_load    = 1'b0;
    rd_we      = 1'b0;
    wb_link    = 1'b0;
    target     = (is_jal || (is_branch && cmp_taken)) ? pc_q + imm : pc_q + Width'(4);

    unique case (state_q)
      StFetch: begin
        // Gated by reset so the request drops the moment reset asserts.
        imem_valid = reset;
        ir_load    = reset && imem_ready;
        if (imem_ready) begin
          cnt_d   = '0;
          state_d = StExec;
        end else if (cnt_q == CntW'(FetchTimeout - 1)) begin
          cause_d = 2'd2;
          state_d = StTrap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        if (!vld_decode) begin
          cause_d = 2'd1;
          state_d = StTrap;
        end else if (is_wfi) begin
          state_d = StWfi;
        end else if (target[1:0] != 2'b00) begin
          cause_d = 2'd3;
          state_d = StTrap;
        end else begin
          rd_we     = rd_valid;
          wb_link   = is_jal;
          pc_d      = target;
          instret_d = instret_q + 1'b1;
          state_d   = StFetch;
        end
      end
      StWfi: begin
        if (irq) begin
          pc_d      = pc_q + Width'(4);
          instret_d = instret_q + 1'b1;
          state_d   = StFetch;
        end
      end
      StTrap: begin
        // Sticky until reset.
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      pc_q      <= ResetPc;
      instret_q <= '0;
      cause_q   <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc         = pc_q;
  assign instret    = instret_q;
  assign trap_cause = cause_q;
  assign link_data  = pc_q + Width'(4);
  assign halted     = (state_q == StWfi);
  assign trap       = (state_q == StTrap);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: behavioural model checked every cycle on the falling
// edge, directed scenarios with literal expectations, then randomized traffic.
module tb_cpu_sequencer;

  localparam int unsigned W   = 32;
  localparam int unsigned FT  = 16;
  localparam logic [31:0] RPC = 32'h0;

  localparam int SF = 0, SE = 1, SW = 2, ST = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready, vld_decode, is_branch, is_jal, is_wfi, rd_valid, cmp_taken, irq;
  logic [31:0] imm;
  logic [31:0] pc, link_data, instret;
  logic        imem_valid, ir_load, rd_we, wb_link, halted, trap;
  logic [1:0]  trap_cause;

  cpu_sequencer #(
    .Width       (W),
    .ResetPc     (RPC),
    .FetchTimeout(FT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_ready (imem_ready),
    .vld_decode (vld_decode),
    .is_branch  (is_branch),
    .is_jal     (is_jal),
    .is_wfi     (is_wfi),
    .rd_valid   (rd_valid),
    .cmp_taken  (cmp_taken),
    .imm        (imm),
    .irq        (irq),
    .pc         (pc),
    .imem_valid (imem_valid),
    .ir_load    (ir_load),
    .rd_we      (rd_we),
    .wb_link    (wb_link),
    .link_data  (link_data),
    .halted     (halted),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the architectural state.
  int          m_st;
  int          m_wait;
  logic [31:0] m_pc, m_ir;
  logic [1:0]  m_cause;

  initial begin
    m_st = SF; m_wait = 0; m_pc = RPC; m_ir = 0; m_cause = 0;
  end

  always @(negedge clk) begin : compare
    logic [31:0] tgt;
    logic        take, ret, e_iv, e_il, e_we, e_wl, e_h, e_t;
    if (!reset) begin
      m_st = SF; m_wait = 0; m_pc = RPC; m_ir = 0; m_cause = 0;
    end
    take = is_jal || (is_branch && cmp_taken);
    tgt  = take ? m_pc + imm : m_pc + 32'd4;
    ret  = reset && (m_st == SE) && vld_decode && !is_wfi && (tgt[1:0] == 2'b00);
    e_iv = reset && (m_st == SF);
    e_il = e_iv && imem_ready;
    e_we = ret && rd_valid;
    e_wl = ret && is_jal;
    e_h  = reset && (m_st == SW);
    e_t  = reset && (m_st == ST);
    chk("pc",         pc,         m_pc);
    chk("instret",    instret,    m_ir);
    chk("trap_cause", trap_cause, m_cause);
    chk("imem_valid", imem_valid, e_iv);
    chk("ir_load",    ir_load,    e_il);
    chk("rd_we",      rd_we,      e_we);
    chk("wb_link",    wb_link,    e_wl);
    chk("link_data",  link_data,  m_pc + 32'd4);
    chk("halted",     halted,     e_h);
    chk("trap",       trap,       e_t);
    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      case (m_st)
        SF: begin
          if (imem_ready) begin m_st = SE; m_wait = 0; end
          else if (m_wait + 1 >= FT) begin m_st = ST; m_cause = 2'd2; end
          else m_wait++;
        end
        SE: begin
          if (!vld_decode) begin m_st = ST; m_cause = 2'd1; end
          else if (is_wfi) m_st = SW;
          else if (tgt[1:0] != 2'b00) begin m_st = ST; m_cause = 2'd3; end
          else begin m_pc = tgt; m_ir = m_ir + 1; m_st = SF; end
        end
        SW: if (irq) begin m_pc = m_pc + 4; m_ir = m_ir + 1; m_st = SF; end
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rdy, input logic vld, input logic br, input logic jal,
                        input logic wfi, input logic rdv, input logic cmp,
                        input logic [31:0] im, input logic irq_v);
    imem_ready = rdy; vld_decode = vld; is_branch = br; is_jal = jal; is_wfi = wfi;
    rd_valid = rdv; cmp_taken = cmp; imm = im; irq = irq_v;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // One fetch hit followed by one EXEC cycle.
  task automatic instr(input logic br, input logic jal, input logic wfi, input logic cmp,
                       input logic [31:0] im, input logic irq_v);
    set_in(1'b1, 1'b1, br, jal, wfi, 1'b1, cmp, im, irq_v);
    step();
    step();
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("rst_imem_valid", imem_valid, 1'b0);
    chk("rst_pc", pc, RPC);
    step();
    reset = 1'b1;
    #1;
    chk("post_rst_imem_valid", imem_valid, 1'b1);
    chk("post_rst_instret", instret, 32'd0);

    // Straight-line code: pc advances by 4 every two cycles.
    plain(6);
    chk("seq_pc", pc, 32'h18);
    chk("seq_instret", instret, 32'd6);

    // Branches from pc 0x10.
    do_reset();
    plain(4);
    instr(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    chk("br_taken_pc", pc, 32'h8);
    plain(2);
    instr(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b0);
    chk("br_not_taken_pc", pc, 32'h14);

    // JAL from pc 0x20.
    plain(3);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0);
    step();
    chk("jal_rd_we", rd_we, 1'b1);
    chk("jal_wb_link", wb_link, 1'b1);
    chk("jal_link_data", link_data, 32'h24);
    step();
    chk("jal_pc", pc, 32'h120);
    chk("jal_instret", instret, 32'd12);

    // WFI at 0x30 with irq already high during EXEC.
    do_reset();
    plain(12);
    instr(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    irq = 1'b0;
    chk("wfi_halted", halted, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("wfi_still_halted", halted, 1'b1);
    irq = 1'b1;
    step();
    chk("wfi_exit_pc", pc, 32'h34);
    chk("wfi_exit_instret", instret, 32'd13);
    chk("wfi_exit_halted", halted, 1'b0);

    // Reset arriving in the middle of WFI.
    instr(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("wfi_rst_pc", pc, RPC);
    chk("wfi_rst_halted", halted, 1'b0);
    step();
    reset = 1'b1;

    // Illegal instruction trap is sticky.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    step();
    chk("illegal_trap", trap, 1'b1);
    for (int i = 0; i < 5; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
             $urandom, $urandom_range(0, 1));
      step();
    end
    chk("illegal_cause_held", trap_cause, 2'd1);

    // Misaligned JAL target.
    do_reset();
    plain(2);
    instr(1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 1'b0);
    chk("misalign_cause", trap_cause, 2'd3);
    chk("misalign_pc", pc, 32'h8);
    chk("misalign_instret", instret, 32'd2);

    // Fetch timeout.
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < FT - 1; i++) step();
    chk("timeout_not_yet", trap, 1'b0);
    step();
    chk("timeout_trap", trap, 1'b1);
    chk("timeout_cause", trap_cause, 2'd2);
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("timeout_held", trap_cause, 2'd2);

    // Ready on the final permitted cycle wins.
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < FT - 1; i++) step();
    imem_ready = 1'b1;
    step();
    chk("late_ready_no_trap", trap, 1'b0);
    chk("late_ready_rd_we", rd_we, 1'b1);
    step();
    chk("late_ready_pc", pc, 32'h4);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] im;
      case ($urandom_range(0, 7))
        6:       im = $urandom;
        7:       im = ($urandom_range(0, 63) << 2) + 32'd1 + 32'($urandom_range(0, 2));
        default: im = ($urandom_range(0, 63) << 2) - 32'd128;
      endcase
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 19) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
             im, $urandom_range(0, 2) == 0);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0 || (m_st == ST && $urandom_range(0, 7) == 0))
        reset = 1'b0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
